// File: rtl/axi_lite_reg_pkg.sv
// Shared types and constants for the AXI4-Lite to register-port bridge.
package axi_lite_reg_pkg;

  localparam int REG_ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WSTB  = 3'd1,
    WRESP = 3'd2,
    RSTB  = 3'd3,
    RCAP  = 3'd4,
    RRESP = 3'd5
  } state_e;

endpackage

// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave that turns single transactions into strobed register-port accesses.
// Optional BRIDGE_ADDR_CHECK_EN: requests outside the BASE_ADDR window get DECERR without strobing.
module axi_lite_reg_bridge
  import axi_lite_reg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [31:0]           s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [REG_ADDR_W-1:0] read_addr,
  output logic                  oe,
  input  logic [31:0]           read_data,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [31:0]           write_data,
  output logic [3:0]            be,
  output logic                  we
);

  state_e                  state_r, state_s;
  logic                    prio_write_r;
  logic                    err_r;
  logic                    wr_acc_s, rd_acc_s;
  logic                    aw_hit_s, ar_hit_s;
  logic [REG_ADDR_W-1:0]   raddr_r, waddr_r;
  logic [31:0]             wdata_r, rdata_r;
  logic [3:0]              be_r;
  logic                    we_r, oe_r, bvalid_r, rvalid_r;
  resp_e                   bresp_r, rresp_r;
  logic                    unused_s;

`ifdef BRIDGE_ADDR_CHECK_EN
  assign aw_hit_s = (s_awaddr[31:18] == BASE_ADDR[31:18]);
  assign ar_hit_s = (s_araddr[31:18] == BASE_ADDR[31:18]);
`else
  assign aw_hit_s = 1'b1;
  assign ar_hit_s = 1'b1;
`endif

  // Address bits outside the word index are intentionally ignored.
  assign unused_s = ^{s_awaddr, s_araddr, BASE_ADDR};

  // Next-state and accept decode; a contested IDLE cycle goes to the prioritised channel.
  always_comb begin
    state_s   = state_r;
    wr_acc_s  = 1'b0;
    rd_acc_s  = 1'b0;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_arready = 1'b0;
    case (state_r)
      IDLE: begin
        if ((s_awvalid && s_wvalid) && (prio_write_r || !s_arvalid)) begin
          wr_acc_s = 1'b1;
          state_s  = WSTB;
        end else if (s_arvalid) begin
          rd_acc_s = 1'b1;
          state_s  = RSTB;
        end else begin
          state_s = IDLE;
        end
      end
      WSTB:  state_s = WRESP;
      WRESP: begin
        if (s_bready) begin
          state_s = IDLE;
        end else begin
          state_s = WRESP;
        end
      end
      RSTB:  state_s = RCAP;
      RCAP:  state_s = RRESP;
      RRESP: begin
        if (s_rready) begin
          state_s = IDLE;
        end else begin
          state_s = RRESP;
        end
      end
      default: state_s = IDLE;
    endcase
    s_awready = wr_acc_s;
    s_wready  = wr_acc_s;
    s_arready = rd_acc_s;
  end

  // State, channel registers and single-cycle strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      prio_write_r <= 1'b1;
      err_r        <= 1'b0;
      raddr_r      <= '0;
      waddr_r      <= '0;
      wdata_r      <= 32'h0000_0000;
      rdata_r      <= 32'h0000_0000;
      be_r         <= 4'h0;
      we_r         <= 1'b0;
      oe_r         <= 1'b0;
      bvalid_r     <= 1'b0;
      rvalid_r     <= 1'b0;
      bresp_r      <= OKAY;
      rresp_r      <= OKAY;
    end else begin
      state_r <= state_s;
      we_r    <= 1'b0;
      oe_r    <= 1'b0;
      if (wr_acc_s) begin
        waddr_r <= s_awaddr[REG_ADDR_W+1:2];
        wdata_r <= s_wdata;
        be_r    <= s_wstrb;
        err_r   <= !aw_hit_s;
        we_r    <= aw_hit_s;
      end
      if (rd_acc_s) begin
        raddr_r <= s_araddr[REG_ADDR_W+1:2];
        err_r   <= !ar_hit_s;
        oe_r    <= ar_hit_s;
      end
      if (state_r == WSTB) begin
        bvalid_r <= 1'b1;
        bresp_r  <= err_r ? DECERR : OKAY;
      end
      if ((state_r == WRESP) && s_bready) begin
        bvalid_r     <= 1'b0;
        prio_write_r <= 1'b0;
      end
      // read_data was registered by the peripheral on the edge that closed RSTB.
      if (state_r == RCAP) begin
        rvalid_r <= 1'b1;
        rdata_r  <= err_r ? 32'h0000_0000 : read_data;
        rresp_r  <= err_r ? DECERR : OKAY;
      end
      if ((state_r == RRESP) && s_rready) begin
        rvalid_r     <= 1'b0;
        prio_write_r <= 1'b1;
      end
    end
  end

  assign s_bvalid   = bvalid_r;
  assign s_bresp    = bresp_r;
  assign s_rvalid   = rvalid_r;
  assign s_rdata    = rdata_r;
  assign s_rresp    = rresp_r;
  assign read_addr  = raddr_r;
  assign oe         = oe_r;
  assign write_addr = waddr_r;
  assign write_data = wdata_r;
  assign be         = be_r;
  assign we         = we_r;

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Directed self-checking bench for axi_lite_reg_bridge with a small register-file peripheral.
module tb_axi_lite_reg_bridge;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_awaddr = 32'h0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = 32'h0;
  logic [3:0]  s_wstrb = 4'h0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b0;
  logic [31:0] s_araddr = 32'h0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic [15:0] read_addr;
  logic        oe;
  logic [31:0] read_data;
  logic [15:0] write_addr;
  logic [31:0] write_data;
  logic [3:0]  be;
  logic        we;

  int n_assert = 0;
  int n_fail   = 0;
  int oe_cnt   = 0;
  int we_cnt   = 0;
  int ov_cnt   = 0;
  logic [31:0] mem [0:15];

  axi_lite_reg_bridge dut (
    .clock(clock), .reset(reset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .read_addr(read_addr), .oe(oe), .read_data(read_data),
    .write_addr(write_addr), .write_data(write_data), .be(be), .we(we)
  );

  always #5 clock = ~clock;

  // Peripheral: byte-enabled register file, read data registered on the oe edge.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0]    <= 32'h0000_1234;
      mem[2]    <= 32'hCAFE_0002;
      mem[3]    <= 32'h1122_3344;
      mem[15]   <= 32'hF00D_000F;
      read_data <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (we && be[b]) mem[write_addr[3:0]][8*b +: 8] <= write_data[8*b +: 8];
      if (oe) read_data <= mem[read_addr[3:0]];
    end
  end

  always @(negedge clock) begin
    if (oe) oe_cnt <= oe_cnt + 1;
    if (we) we_cnt <= we_cnt + 1;
    if (oe && we) ov_cnt <= ov_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [15:0] e_waddr,
                          input logic e_we, input logic [1:0] e_resp);
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    #1;
    chk({tag, "_ready"}, {s_awready, s_wready}, 2'b11);
    cyc();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk({tag, "_we"}, we, e_we);
    chk({tag, "_port"}, {write_addr, be, write_data}, {e_waddr, strb, data});
    cyc();
    chk({tag, "_resp"}, {we, s_bvalid, s_bresp}, {1'b0, 1'b1, e_resp});
    cyc();
    chk({tag, "_done"}, s_bvalid, 1'b0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [15:0] e_raddr,
                         input logic [31:0] e_data, input logic [1:0] e_resp, input logic e_oe);
    s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
    #1;
    chk({tag, "_ready"}, s_arready, 1'b1);
    cyc();
    s_arvalid = 1'b0;
    chk({tag, "_oe"}, {oe, read_addr}, {e_oe, e_raddr});
    cyc();
    chk({tag, "_cap"}, {oe, s_rvalid}, 2'b00);
    cyc();
    chk({tag, "_resp"}, {s_rvalid, s_rresp, s_rdata}, {1'b1, e_resp, e_data});
    cyc();
    chk({tag, "_done"}, s_rvalid, 1'b0);
  endtask

  initial begin
    int t;
    int snap;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ctl", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, oe, we}, 7'b0);
    chk("reset_addr", {read_addr, write_addr, be}, 36'h0);
    chk("reset_data", {write_data, s_rdata, s_bresp, s_rresp}, 68'h0);
    reset = 1'b0;
    cyc();

    // AW without W, and W without AW, must not be accepted.
    s_awaddr = 32'h4000_0004; s_awvalid = 1'b1;
    #1;
    chk("aw_only_ready", {s_awready, s_wready}, 2'b00);
    s_awvalid = 1'b0; s_wvalid = 1'b1;
    #1;
    chk("w_only_ready", {s_awready, s_wready}, 2'b00);
    cyc();
    chk("w_only_no_we", we, 1'b0);
    s_wvalid = 1'b0;

    do_write("wr1", 32'h4000_0004, 32'hDEAD_BEEF, 4'hF, 16'h0001, 1'b1, 2'b00);
    do_read("rd1", 32'h4000_0000, 16'h0000, 32'h0000_1234, 2'b00, 1'b1);

    // Contested requests: grants alternate W,R,W,R.
    snap = oe_cnt + we_cnt;
    s_awaddr = 32'h4000_000C; s_wdata = 32'hA5A5_5A5A; s_wstrb = 4'b0011;
    s_araddr = 32'h4000_0004;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    s_bready = 1'b1; s_rready = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      t = 0;
      while (!(s_awready || s_arready) && t < 20) begin
        cyc();
        t++;
      end
      chk($sformatf("grant%0d_seen", g), (t < 20), 1'b1);
      chk($sformatf("grant%0d_kind", g), {s_awready, s_arready}, (g % 2 == 0) ? 2'b10 : 2'b01);
      cyc();
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    repeat (4) cyc();
    chk("rr_strobes", oe_cnt + we_cnt - snap, 4);
    chk("rr_no_overlap", ov_cnt, 0);
    chk("rr_rdata", {s_rvalid, s_rdata}, {1'b0, 32'hDEAD_BEEF});

    // Read backpressure: response held stable, no new strobes.
    s_araddr = 32'h4000_000C; s_arvalid = 1'b1; s_rready = 1'b0;
    cyc();
    s_arvalid = 1'b0;
    cyc();
    cyc();
    snap = oe_cnt + we_cnt;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_hold", k), {s_rvalid, s_rresp, s_rdata, oe}, {1'b1, 2'b00, 32'h1122_5A5A, 1'b0});
      cyc();
    end
    chk("bp_no_strobe", oe_cnt + we_cnt - snap, 0);
    s_rready = 1'b1;
    #1;
    chk("bp_still_valid", s_rvalid, 1'b1);
    cyc();
    chk("bp_done", s_rvalid, 1'b0);

    // Reset while in RSTB drops the read.
    s_araddr = 32'h4000_0000; s_arvalid = 1'b1; s_rready = 1'b0;
    cyc();
    s_arvalid = 1'b0;
    chk("rst_mid_oe_before", oe, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid_oe_drop", oe, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    s_rready = 1'b1;
    repeat (4) cyc();
    chk("rst_mid_no_rvalid", {s_rvalid, s_bvalid}, 2'b00);

    // After reset a contested request goes to the write first again.
    s_awaddr = 32'h4000_0010; s_wdata = 32'h0000_0077; s_wstrb = 4'hF;
    s_araddr = 32'h4000_0008;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1; s_bready = 1'b1;
    #1;
    chk("post_rst_grant", {s_awready, s_arready}, 2'b10);
    cyc();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    cyc();
    cyc();
    chk("post_rst_ar_ready", s_arready, 1'b1);
    cyc();
    s_arvalid = 1'b0;
    chk("post_rst_oe", {oe, read_addr}, {1'b1, 16'h0002});
    cyc();
    cyc();
    chk("post_rst_resp", {s_rvalid, s_rresp, s_rdata}, {1'b1, 2'b00, 32'hCAFE_0002});
    cyc();

    // Top word of the window, low address bits ignored.
    do_read("rd_top", 32'h4003_FFFE, 16'hFFFF, 32'hF00D_000F, 2'b00, 1'b1);

`ifdef BRIDGE_ADDR_CHECK_EN
    snap = oe_cnt + we_cnt;
    do_read("rd_decerr", 32'h5000_0000, 16'h0000, 32'h0000_0000, 2'b11, 1'b0);
    do_write("wr_decerr", 32'h5000_0008, 32'h1111_2222, 4'hF, 16'h0002, 1'b0, 2'b11);
    chk("decerr_no_strobe", oe_cnt + we_cnt - snap, 0);
`else
    do_read("rd_alias", 32'h5000_0000, 16'h0000, 32'h0000_1234, 2'b00, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
